reg_file_write_back: RTL
========================

REG_FILE_WRITE_BACK -- requirements
Module: reg_file_write_back

Interface
REQ-001 The block SHALL have parameter SEL_WIDTH, default 4, the register-select width (16 registers).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-003 The block SHALL have parameter DEPTH, default 4 (power of two, >=2), the long-result queue depth.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 exec_valid  input  1  single-cycle execute result present this cycle.
REQ-007 exec_sel  input  SEL_WIDTH  destination register of exec result.
REQ-008 exec_data  input  DATA_WIDTH  exec result data.
REQ-009 long_valid  input  1  multi-cycle unit (mul/div/load) result offered.
REQ-010 long_sel  input  SEL_WIDTH  destination register of long result.
REQ-011 long_data  input  DATA_WIDTH  long result data.
REQ-012 long_ready  output  1  long result accepted this cycle when high together with long_valid.
REQ-013 claim_valid  input  1  decode issues a long op; mark claim_sel pending.
REQ-014 claim_sel  input  SEL_WIDTH  register being claimed.
REQ-015 pending_mask  output  2**SEL_WIDTH  bit n high = register n awaits a long result.
REQ-016 write_en  output  1  register-file write enable (registered).
REQ-017 write_sel  output  SEL_WIDTH  register-file write select (registered).
REQ-018 write_data  output  DATA_WIDTH  register-file write data (registered).
REQ-019 queue_count  output  clog2(DEPTH)+1  entries held in long-result queue.

Function
REQ-020 The write port SHALL perform at most one write per cycle; write_en/write_sel/write_data SHALL update one cycle after the winning source is selected (latency 1).
REQ-021 Priority: exec_valid SHALL win the write port unconditionally; exec results are never queued and never back-pressured.
REQ-022 If exec_valid=0 and queue non-empty, the queue head SHALL be popped and written.
REQ-023 If exec_valid=0, queue empty and long_valid=1, the long result SHALL bypass the queue and be written directly (long_ready=1, no enqueue).
REQ-024 If exec_valid=1 and long_valid=1 and long_ready=1, the long result SHALL be enqueued at the tail.
REQ-025 If exec_valid=0, queue non-empty and long_valid=1 and long_ready=1, head SHALL pop and the new result SHALL enqueue in the same cycle (count unchanged).
REQ-026 long_ready SHALL equal (queue_count != DEPTH) while rst_n=1 and SHALL be 0 while rst_n=0; long_ready SHALL NOT depend on long_valid or exec_valid.
REQ-027 Queue SHALL be FIFO-ordered; read/write pointers SHALL wrap modulo DEPTH.
REQ-028 When no source writes, write_en SHALL be 0 next cycle and write_sel/write_data SHALL hold their previous values.
REQ-029 A claim SHALL set pending_mask[claim_sel] on the next edge.
REQ-030 A long result reaching the write port (bypass or pop) SHALL clear pending_mask[sel] on the same edge that asserts write_en.
REQ-031 Simultaneous claim and clear of the same register SHALL leave the bit set.
REQ-032 Exec writes SHALL NOT alter pending_mask; WAW ordering against pending registers is decode's duty via pending_mask.
REQ-033 pending_mask and queue_count SHALL be driven directly from registers (no combinational input paths).

Reset
REQ-034 On a clock edge with rst_n=0: queue_count=0, pointers=0, pending_mask=0, write_en=0, write_sel=0, write_data=0; queued entries are discarded.
REQ-035 Reset asserted mid-operation SHALL discard queued and in-flight results; the first write after release SHALL come only from inputs sampled after release.

Verification
REQ-036 Exec only: exec_valid=1, sel=3, data=0xDEADBEEF -> next cycle write_en=1, write_sel=3, write_data=0xDEADBEEF; following idle cycle write_en=0.
REQ-037 Bypass: claim r5; later long_valid=1 sel=5 data=0x12, exec_valid=0, queue empty -> long_ready=1, next cycle write r5=0x12, pending_mask[5] 1->0, queue_count stays 0.
REQ-038 Conflict: exec (r1,0xA) and long (r2,0xB) same cycle -> r1 written first, queue_count=1, then r2=0xB next idle cycle, queue_count=0.
REQ-039 Full: exec_valid held 1 while offering 5 long results -> after 4 accepted queue_count=4, long_ready=0, 5th held; drop exec_valid -> drained in order, 5th accepted once count<4.
REQ-040 Claim/clear collision: pending r7, long result r7 writes same cycle as new claim r7 -> pending_mask[7] remains 1.
REQ-041 Reset mid-drain: queue_count=3, rst_n=0 one edge -> queue_count=0, write_en=0, pending_mask=0, long_ready=0 during reset, 1 after release.

Source files
------------

// File: rtl/reg_file_write_back_if.sv
// Write-back bundle: exec result, long-op result handshake, claims, and register-file write port.
// Latency: none (signal grouping only).
// Backpressure: long_valid/long_ready handshake; exec and claim have no backpressure.
interface reg_file_write_back_if #(
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                        exec_valid;
  logic [SEL_WIDTH-1:0]        exec_sel;
  logic [DATA_WIDTH-1:0]       exec_data;
  logic                        long_valid;
  logic [SEL_WIDTH-1:0]        long_sel;
  logic [DATA_WIDTH-1:0]       long_data;
  logic                        long_ready;
  logic                        claim_valid;
  logic [SEL_WIDTH-1:0]        claim_sel;
  logic [(1<<SEL_WIDTH)-1:0]   pending_mask;
  logic                        write_en;
  logic [SEL_WIDTH-1:0]        write_sel;
  logic [DATA_WIDTH-1:0]       write_data;
  logic [CNT_W-1:0]            queue_count;

  // Pipeline side: drives results and claims, observes the write port.
  modport master (
    output exec_valid, exec_sel, exec_data,
    output long_valid, long_sel, long_data,
    output claim_valid, claim_sel,
    input  long_ready, pending_mask,
    input  write_en, write_sel, write_data, queue_count
  );

  // Write-back block side.
  modport slave (
    input  exec_valid, exec_sel, exec_data,
    input  long_valid, long_sel, long_data,
    input  claim_valid, claim_sel,
    output long_ready, pending_mask,
    output write_en, write_sel, write_data, queue_count
  );
endinterface

// File: rtl/reg_file_write_back.sv
// Small generic FIFO holding parked long-op results for the write-back arbiter.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: caller must not push when full nor pop when empty; no internal guard.
module rfwb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; contents are don't-care once pointers reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH)+1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH)+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Register-file write-back arbiter: exec results win, long results bypass or queue; tracks pending regs.
// Latency: 1 cycle from winning source to registered write_en/write_sel/write_data.
// Backpressure: exec never stalled; long_ready low only when the queue is full or in reset.
module reg_file_write_back #(
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_file_write_back_if.slave  wb
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << SEL_WIDTH;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } long_ent_t;

  long_ent_t             push_ent;
  long_ent_t             head_ent;
  logic [CNT_W-1:0]      q_count;
  logic                  q_empty;
  logic                  long_rdy;
  logic                  long_acc;
  logic                  q_push;
  logic                  q_pop;

  logic                  nxt_en;
  logic [SEL_WIDTH-1:0]  nxt_sel;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  long_wr;

  logic [NREG-1:0]       clr_vec;
  logic [NREG-1:0]       set_vec;
  logic [NREG-1:0]       pending_q;

  logic                  wr_en_q;
  logic [SEL_WIDTH-1:0]  wr_sel_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // Ready depends only on occupancy and reset so upstream never sees a combinational loop.
  assign long_rdy = rst_n & (q_count != CNT_W'(DEPTH));
  assign long_acc = wb.long_valid & long_rdy;
  assign q_empty  = (q_count == '0);

  assign push_ent.sel  = wb.long_sel;
  assign push_ent.data = wb.long_data;

  // Write-port arbitration: exec first, then queue head, then direct bypass of the offered long result.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_sel  = wr_sel_q;
    nxt_data = wr_data_q;
    long_wr  = 1'b0;
    q_push   = 1'b0;
    q_pop    = 1'b0;
    if (wb.exec_valid) begin
      nxt_en   = 1'b1;
      nxt_sel  = wb.exec_sel;
      nxt_data = wb.exec_data;
      q_push   = long_acc;
    end else if (!q_empty) begin
      nxt_en   = 1'b1;
      nxt_sel  = head_ent.sel;
      nxt_data = head_ent.data;
      long_wr  = 1'b1;
      q_pop    = 1'b1;
      q_push   = long_acc;
    end else if (long_acc) begin
      nxt_en   = 1'b1;
      nxt_sel  = wb.long_sel;
      nxt_data = wb.long_data;
      long_wr  = 1'b1;
    end
  end

  rfwb_fifo #(
    .WIDTH ($bits(long_ent_t)),
    .DEPTH (DEPTH)
  ) u_long_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_dat (push_ent),
    .pop      (q_pop),
    .head_dat (head_ent),
    .count    (q_count)
  );

  // One-hot set/clear vectors for the pending scoreboard.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    clr_vec[nxt_sel]      = long_wr;
    set_vec[wb.claim_sel] = wb.claim_valid;
  end

  // Pending scoreboard: set after clear so a same-cycle claim of a retiring register keeps it pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | set_vec;
    end
  end

  // Registered write port; select/data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= nxt_en;
      wr_sel_q  <= nxt_sel;
      wr_data_q <= nxt_data;
    end
  end

  assign wb.long_ready   = long_rdy;
  assign wb.pending_mask = pending_q;
  assign wb.queue_count  = q_count;
  assign wb.write_en     = wr_en_q;
  assign wb.write_sel    = wr_sel_q;
  assign wb.write_data   = wr_data_q;
endmodule
